msrv32_integer_file: RTL and testbench
======================================

// Module: msrv32_integer_file
// PURPOSE
//  32 x 32-bit integer register file (x0..x31) for the MSRV32 core; write-side consumer of
//  wr_en_integer_file_out from msrv32_wr_en_generator. Two combinational read ports feed
//  decode/execute; one synchronous write port is driven from the writeback stage. Write-through
//  bypass lets a same-cycle write be read back with zero latency. x0 is hardwired to zero.
// PARAMETERS
//  XLEN       32   data width of each register
//  NREGS      32   number of architectural registers (address width = clog2(NREGS) = 5)
//  BYPASS_EN  1    1: same-cycle write forwarded to read ports; 0: old value read until next edge
// PORTS
//  ms_riscv32_mp_clk_in    in   1     core clock, all state updates on rising edge
//  ms_riscv32_mp_rst_n_in  in   1     asynchronous active-low reset
//  rs_1_addr_in            in   5     read port 1 register index
//  rs_2_addr_in            in   5     read port 2 register index
//  rd_addr_in              in   5     write register index
//  wr_en_in                in   1     write enable (= wr_en_integer_file_out, already flush-gated)
//  rd_in                   in   XLEN  write data
//  rs_1_out                out  XLEN  read data port 1
//  rs_2_out                out  XLEN  read data port 2
// BEHAVIOUR
//  - Reset: reset is asynchronous and active-low; while ms_riscv32_mp_rst_n_in=0 all registers
//    x1..x31 are cleared to 0 immediately, independent of the clock; the read ports then return 0.
//  - Write: on the rising edge with wr_en_in=1 and rd_addr_in!=0, reg[rd_addr_in] <= rd_in.
//    wr_en_in=0 leaves every register unchanged. A write to x0 is discarded without error.
//  - Read: rs_N_out is combinational from rs_N_addr_in and has zero-cycle latency.
//    If rs_N_addr_in==0, rs_N_out=0 unconditionally. This includes bypass and the write-to-x0 case.
//  - Bypass (BYPASS_EN=1): if wr_en_in=1, rd_addr_in!=0 and rd_addr_in==rs_N_addr_in, then
//    rs_N_out=rd_in in that same cycle. Both ports are bypassed independently. When both read
//    addresses match rd_addr_in, both ports output rd_in.
//  - BYPASS_EN=0: the same case returns the stored (old) value until after the clock edge.
//  - Reset asserted in the same cycle as a write: reset wins; the register stays 0 after the edge.
//    Bypass is suppressed while reset is asserted, so the read ports output 0.
//  - Reset deasserted mid-cycle: the first write takes effect at the first rising edge that
//    occurs with ms_riscv32_mp_rst_n_in=1.
//  - Back-to-back writes to the same index: the last write wins, and each write is visible at
//    the edge that follows it.
//  - Address inputs are always 5 bits, and every value maps to a valid register; there is no
//    out-of-range case.
//  - Storage is x1..x31 only. x0 has no flop, so an implementation holds 31*XLEN flops.
// STRUCTURE
//  - Shared package msrv32_pkg: XLEN, NREGS, REG_ADDR_W=5, and constant ZERO_REG=5'd0.
//  - One natural sub-module: msrv32_rf_read_port (address, storage view, write-side bypass
//    inputs -> data), instantiated twice so both ports have identical zero and bypass logic.
//  - The storage array plus write decode stays in the top module. No FSM. The only state is the
//    register array.
// TESTING
//  1 Reset: hold rst_n=0, then read all 32 indices on both ports -> every read returns 0.
//    Assert rst_n mid-cycle with no clock edge -> outputs go to 0 immediately.
//  2 Write/read: write x5=32'hDEAD_BEEF with wr_en=1, then read rs_1=5, rs_2=5 on the next
//    cycle -> both return 32'hDEAD_BEEF. Neighbours x4 and x6 still read 0.
//  3 x0 write: wr_en=1, rd=0, data=32'hFFFF_FFFF -> rs_1_addr=0 returns 0 in the same cycle and
//    afterwards. No other register changes.
//  4 Bypass: x7 holds 32'h1111_1111. In one cycle drive wr_en=1, rd=7, data=32'h2222_2222,
//    rs_1=7, rs_2=7 -> both ports output 32'h2222_2222 before the edge. With BYPASS_EN=0 they
//    output 32'h1111_1111 until after the edge.
//  5 Gated write: wr_en=0, rd=9, data=32'hABCD -> x9 is unchanged at 0. Repeat with wr_en=1
//    and rst_n=0 on the same edge -> x9 is still 0.
//  6 Full sweep: write x[i]=i*32'h0101_0101 for i=1..31 on consecutive cycles, then read every
//    pair (i,31-i) -> both ports return the matching values and x0 reads 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared MSRV32 constants: datapath width, register count and index width.
package msrv32_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One register-file read port: x0 forced to zero, optional write-through bypass.
module msrv32_rf_read_port
    import msrv32_pkg::*;
#(
    parameter int XLEN_P    = msrv32_pkg::XLEN,
    parameter int NREGS_P   = msrv32_pkg::NREGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                           rst_n_i,
    input  logic [REG_ADDR_W-1:0]          addr_i,
    input  logic [NREGS_P-1:0][XLEN_P-1:0] regs_i,
    input  logic                           wr_en_i,
    input  logic [REG_ADDR_W-1:0]          wr_addr_i,
    input  logic [XLEN_P-1:0]              wr_data_i,
    output logic [XLEN_P-1:0]              data_o
);

    logic bypass_hit;

    // Forward an in-flight write; suppressed during reset so reads stay at zero.
    assign bypass_hit = BYPASS_EN && rst_n_i && wr_en_i &&
                        (wr_addr_i != ZERO_REG) && (wr_addr_i == addr_i);

    // Select stored value, then bypass, then force x0 to zero last so it always wins.
    always_comb begin
        data_o = regs_i[addr_i];
        if (bypass_hit)
            data_o = wr_data_i;
        if (addr_i == ZERO_REG)
            data_o = '0;
    end

endmodule

// File: rtl/msrv32_integer_file.sv
// 32 x XLEN integer register file: two combinational read ports, one synchronous write port.
module msrv32_integer_file
    import msrv32_pkg::*;
#(
    parameter int XLEN      = msrv32_pkg::XLEN,
    parameter int NREGS     = msrv32_pkg::NREGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_n_in,
    input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  wr_en_in,
    input  logic [XLEN-1:0]       rd_in,
    output logic [XLEN-1:0]       rs_1_out,
    output logic [XLEN-1:0]       rs_2_out
);

    // x0 has no storage; only x1..x(NREGS-1) are flops.
    logic [NREGS-1:1][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0][XLEN-1:0] regs_view;

    // Read ports see a full array with a constant-zero slot at index 0.
    assign regs_view = {regs_q, {XLEN{1'b0}}};

    // Write decode: update only the addressed register; writes to x0 are dropped.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en_in && (rd_addr_in == REG_ADDR_W'(i)))
                regs_d[i] = rd_in;
        end
    end

    // Register array: async clear, rising-edge update.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    msrv32_rf_read_port #(
        .XLEN_P    (XLEN),
        .NREGS_P   (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd_port_1 (
        .rst_n_i   (ms_riscv32_mp_rst_n_in),
        .addr_i    (rs_1_addr_in),
        .regs_i    (regs_view),
        .wr_en_i   (wr_en_in),
        .wr_addr_i (rd_addr_in),
        .wr_data_i (rd_in),
        .data_o    (rs_1_out)
    );

    msrv32_rf_read_port #(
        .XLEN_P    (XLEN),
        .NREGS_P   (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd_port_2 (
        .rst_n_i   (ms_riscv32_mp_rst_n_in),
        .addr_i    (rs_2_addr_in),
        .regs_i    (regs_view),
        .wr_en_i   (wr_en_in),
        .wr_addr_i (rd_addr_in),
        .wr_data_i (rd_in),
        .data_o    (rs_2_out)
    );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed + random bench for msrv32_integer_file against an array-based reference model.
module tb_msrv32_integer_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] wd;
    logic [31:0] o1, o2;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model [32];

    msrv32_integer_file dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .rs_1_addr_in           (rs1),
        .rs_2_addr_in           (rs2),
        .rd_addr_in             (rd),
        .wr_en_in               (we),
        .rd_in                  (wd),
        .rs_1_out               (o1),
        .rs_2_out               (o2)
    );

    always #5 clk = ~clk;

    // Architectural read: x0 is zero, reset reads zero, a pending write is visible now.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0 || !rst_n) return 32'h0;
        if (we && rd == a)       return wd;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, ".rs1"}, o1, ref_read(rs1));
        check({tag, ".rs2"}, o2, ref_read(rs2));
    endtask

    task automatic set_reset(input logic v);
        rst_n = v;
        if (!v) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, commit the write in the model, land just after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && we && rd != 5'd0) model[rd] = wd;
        #2;
    endtask

    initial begin
        we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
        set_reset(1'b0);
        #12;

        // Reset holds every register at zero on both ports
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            check("reset.rs1", o1, 32'h0);
            check("reset.rs2", o2, 32'h0);
        end
        @(negedge clk);
        set_reset(1'b1);
        #1;

        // Basic write then read
        we = 1'b1; rd = 5'd5; wd = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
        #1;
        check("wr.x5.rs1", o1, 32'hDEAD_BEEF);
        check("wr.x5.rs2", o2, 32'hDEAD_BEEF);
        rs1 = 5'd4; rs2 = 5'd6;
        #1;
        check("wr.x4", o1, 32'h0);
        check("wr.x6", o2, 32'h0);

        // Write to x0 is discarded, same cycle and after
        we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd5;
        #1;
        check("x0.same.rs1", o1, 32'h0);
        check("x0.same.rs2", o2, 32'hDEAD_BEEF);
        tick();
        we = 1'b0;
        #1;
        check("x0.after.rs1", o1, 32'h0);
        check("x0.after.rs2", o2, 32'hDEAD_BEEF);

        // Same-cycle bypass on both ports
        we = 1'b1; rd = 5'd7; wd = 32'h1111_1111;
        tick();
        wd = 32'h2222_2222; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        check("byp.rs1", o1, 32'h2222_2222);
        check("byp.rs2", o2, 32'h2222_2222);
        tick();
        we = 1'b0;
        #1;
        check("byp.after.rs1", o1, 32'h2222_2222);
        check("byp.after.rs2", o2, 32'h2222_2222);

        // Gated write leaves x9 alone
        we = 1'b0; rd = 5'd9; wd = 32'h0000_ABCD; rs1 = 5'd9; rs2 = 5'd5;
        tick();
        #1;
        check("gated.x9", o1, 32'h0);
        check("gated.x5", o2, 32'hDEAD_BEEF);

        // Reset asserted mid-cycle together with a write: reset wins, no bypass
        we = 1'b1;
        set_reset(1'b0);
        #1;
        check("rstwr.same.x9", o1, 32'h0);
        check("rstwr.async.x5", o2, 32'h0);
        tick();
        set_reset(1'b1); we = 1'b0;
        #1;
        check("rstwr.after.x9", o1, 32'h0);
        check("rstwr.after.x5", o2, 32'h0);

        // Full sweep
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i); wd = i * 32'h0101_0101;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            check("sweep.rs1", o1, (i == 0) ? 32'h0 : i * 32'h0101_0101);
            check("sweep.rs2", o2, (i == 31) ? 32'h0 : (31 - i) * 32'h0101_0101);
        end

        // Back-to-back writes to one index: last wins, each visible after its edge
        @(negedge clk); #1;
        we = 1'b1; rd = 5'd3; wd = 32'hAAAA_0001; rs1 = 5'd3; rs2 = 5'd4;
        tick();
        wd = 32'hBBBB_0002;
        #1;
        check("b2b.first", o2, 32'h0404_0404);
        vectors++;
        assert (model[3] === 32'hAAAA_0001) else begin
            miscompares++;
            $error("FAIL b2b.model: observed %h expected %h", model[3], 32'hAAAA_0001);
        end
        tick();
        we = 1'b0;
        #1;
        check("b2b.last", o1, 32'hBBBB_0002);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom);
            wd  = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            if ($urandom_range(0, 40) == 0) set_reset(1'b0);
            check_ports("rand");
            tick();
            if (!rst_n) set_reset(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
